// File: rtl/aes_idec_ctrl_pkg.sv
// Shared constants and types for the iterative AES inverse-cipher sequencer.
package aes_idec_ctrl_pkg;

    localparam int NB = 4;
    localparam int NR = 10;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        FINAL,
        DONE
    } fsm_e;

    // Byte i is input byte i (FIPS-197 ordering): row r, column c lives at r + 4*c.
    typedef logic [0:4*NB-1][7:0] state_t;

endpackage

// File: rtl/aes_idec_ctrl_if.sv
// Handshake, key-store and round-datapath signals around the sequencer.
interface aes_idec_ctrl_if;
    import aes_idec_ctrl_pkg::*;

    logic       key_valid;
    logic       in_valid;
    logic       in_ready;
    state_t     ct;
    state_t     rk;
    logic [3:0] round_index;
    state_t     state_q;
    state_t     iround_state;
    state_t     final_state;
    logic       out_valid;
    logic       out_ready;
    state_t     pt;
    logic       busy;
    logic       clear;

    modport slave (
        input  key_valid, in_valid, ct, rk, iround_state, final_state, out_ready, clear,
        output in_ready, round_index, state_q, out_valid, pt, busy
    );

    modport master (
        output key_valid, in_valid, ct, rk, iround_state, final_state, out_ready, clear,
        input  in_ready, round_index, state_q, out_valid, pt, busy
    );

endinterface

// File: rtl/aes_idec_ctrl_arkey_init.sv
// Initial AddRoundKey: 16 independent byte lanes of ct XOR rk.
module aes_arkey_init
    import aes_idec_ctrl_pkg::*;
(
    input  state_t ct_i,
    input  state_t rk_i,
    output state_t ark_o
);

    for (genvar i = 0; i < 4*NB; i++) begin : g_lane
        assign ark_o[i] = ct_i[i] ^ rk_i[i];
    end

endmodule

// File: rtl/aes_idec_ctrl.sv
// Iterative AES inverse-cipher sequencer: owns the state register and round index,
// steps an external inverse round and final-round block, one block in flight at a time.
module aes_idec_ctrl
    import aes_idec_ctrl_pkg::*;
#(
    parameter int ROUNDS = NR
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    aes_idec_ctrl_if.slave bus
);

    localparam logic [3:0] IDX_TOP   = 4'(ROUNDS);
    localparam logic [3:0] IDX_FIRST = 4'(ROUNDS - 1);

    fsm_e       fsm_q, fsm_d;
    logic [3:0] idx_q, idx_d;
    state_t     data_q, data_d;
    state_t     ark;
    logic       in_ready;
    logic       accept;

    aes_arkey_init u_arkey (
        .ct_i  (bus.ct),
        .rk_i  (bus.rk),
        .ark_o (ark)
    );

    assign accept = in_ready && bus.in_valid;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fsm_q  <= IDLE;
            idx_q  <= IDX_TOP;
            data_q <= '0;
        end else begin
            fsm_q  <= fsm_d;
            idx_q  <= idx_d;
            data_q <= data_d;
        end
    end

    // clear wins over everything; state_q deliberately keeps its last contents on abort.
    always_comb begin
        fsm_d  = fsm_q;
        idx_d  = idx_q;
        data_d = data_q;
        if (bus.clear) begin
            fsm_d = IDLE;
            idx_d = IDX_TOP;
        end else begin
            case (fsm_q)
                IDLE: begin
                    idx_d = IDX_TOP;
                    if (accept) begin
                        data_d = ark;
                        idx_d  = IDX_FIRST;
                        fsm_d  = ROUND;
                    end
                end
                ROUND: begin
                    data_d = bus.iround_state;
                    idx_d  = idx_q - 4'd1;
                    if (idx_q == 4'd1) begin
                        fsm_d = FINAL;
                    end
                end
                FINAL: begin
                    data_d = bus.final_state;
                    fsm_d  = DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        fsm_d = IDLE;
                        idx_d = IDX_TOP;
                    end
                end
                default: begin
                    fsm_d = IDLE;
                    idx_d = IDX_TOP;
                end
            endcase
        end
    end

    // in_ready depends only on state, key_valid and clear, never on in_valid.
    always_comb begin
        in_ready        = (fsm_q == IDLE) && bus.key_valid && !bus.clear;
        bus.in_ready    = in_ready;
        bus.out_valid   = (fsm_q == DONE);
        bus.busy        = (fsm_q != IDLE);
        bus.round_index = idx_q;
        bus.state_q     = data_q;
        bus.pt          = data_q;
    end

endmodule

// File: tb/tb_aes_idec_ctrl.sv
// Bench for aes_idec_ctrl: NR=10 and NR=14 instances with a behavioural AES environment.
module tb_aes_idec_ctrl;
    import aes_idec_ctrl_pkg::*;

    typedef struct packed {
        logic       in_ready;
        logic [3:0] idx;
        logic       out_valid;
        logic       busy;
        state_t     pt;
        state_t     sq;
    } snap_t;

    logic   clk = 1'b0;
    logic   rst_n;
    int     checks = 0;
    int     errors = 0;
    logic [7:0] sbox  [256];
    logic [7:0] isbox [256];
    state_t rk10 [15];
    state_t rk14 [15];

    localparam state_t FIPS_PT = 128'h00112233445566778899aabbccddeeff;
    localparam state_t C1_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam state_t C3_CT   = 128'h8ea2b7ca516745bfeafc49904b496089;

    aes_idec_ctrl_if b10 ();
    aes_idec_ctrl_if b14 ();

    aes_idec_ctrl #(.ROUNDS(10)) dut10 (.clk_i(clk), .rst_ni(rst_n), .bus(b10));
    aes_idec_ctrl #(.ROUNDS(14)) dut14 (.clk_i(clk), .rst_ni(rst_n), .bus(b14));

    always #5 clk = ~clk;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int k = 0; k < 8; k++) begin
            if (bb[0]) p = p ^ aa;
            aa = xt(aa);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic state_t sub_bytes(input state_t s, input bit inv);
        state_t o;
        for (int i = 0; i < 16; i++) o[i] = inv ? isbox[s[i]] : sbox[s[i]];
        return o;
    endfunction

    function automatic state_t shift_rows(input state_t s, input bit inv);
        state_t o;
        o = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (inv) o[r + 4*((c + r) % 4)] = s[r + 4*c];
                else     o[r + 4*c] = s[r + 4*((c + r) % 4)];
        return o;
    endfunction

    function automatic state_t mix_cols(input state_t s, input bit inv);
        logic [7:0] cf [4];
        state_t o;
        if (inv) cf = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     cf = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int c = 0; c < 4; c++)
            for (int i = 0; i < 4; i++) begin
                o[4*c + i] = 8'h00;
                for (int k = 0; k < 4; k++)
                    o[4*c + i] = o[4*c + i] ^ gm(s[4*c + (i + k) % 4], cf[k]);
            end
        return o;
    endfunction

    function automatic state_t inv_round(input state_t s, input state_t k);
        return mix_cols(sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ k, 1'b1);
    endfunction

    function automatic state_t inv_final(input state_t s, input state_t k);
        return sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ k;
    endfunction

    function automatic state_t get_rk(input bit big, input int r);
        return big ? rk14[r] : rk10[r];
    endfunction

    // Reference model: forward cipher, so the DUT must undo it.
    function automatic state_t encrypt(input state_t p, input bit big);
        int nr;
        state_t s;
        nr = big ? 14 : 10;
        s = p ^ get_rk(big, 0);
        for (int r = 1; r < nr; r++)
            s = mix_cols(shift_rows(sub_bytes(s, 1'b0), 1'b0), 1'b0) ^ get_rk(big, r);
        return shift_rows(sub_bytes(s, 1'b0), 1'b0) ^ get_rk(big, nr);
    endfunction

    function automatic state_t rnd();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Environment: inverse round, final round and key store driven from the DUT outputs.
    assign b10.rk           = rk10[b10.round_index];
    assign b10.iround_state = inv_round(b10.state_q, b10.rk);
    assign b10.final_state  = inv_final(b10.state_q, b10.rk);
    assign b14.rk           = rk14[b14.round_index];
    assign b14.iround_state = inv_round(b14.state_q, b14.rk);
    assign b14.final_state  = inv_final(b14.state_q, b14.rk);

    task automatic build_sbox();
        logic [7:0] inv, v;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            v = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox[x]  = v;
            isbox[v] = 8'(x);
        end
    endtask

    task automatic key_expand(input logic [255:0] key, input int nk, input bit big);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4*(nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++)
            for (int c = 0; c < 4; c++)
                for (int j = 0; j < 4; j++)
                    if (big) rk14[r][4*c + j] = w[4*r + c][31 - 8*j -: 8];
                    else     rk10[r][4*c + j] = w[4*r + c][31 - 8*j -: 8];
    endtask

    task automatic drv(input bit big, input bit kv, input bit iv, input state_t c,
                       input bit ordy, input bit clr);
        if (big) begin
            b14.key_valid = kv; b14.in_valid = iv; b14.ct = c;
            b14.out_ready = ordy; b14.clear = clr;
        end else begin
            b10.key_valid = kv; b10.in_valid = iv; b10.ct = c;
            b10.out_ready = ordy; b10.clear = clr;
        end
    endtask

    function automatic snap_t snap(input bit big);
        snap_t s;
        if (big) s = '{b14.in_ready, b14.round_index, b14.out_valid, b14.busy, b14.pt, b14.state_q};
        else     s = '{b10.in_ready, b10.round_index, b10.out_valid, b10.busy, b10.pt, b10.state_q};
        return s;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Entered and left at a falling edge; expects the DUT idle with key available.
    task automatic run_block(input bit big, input state_t ct, input state_t exp,
                             input string tag, input int hold);
        int nr;
        snap_t s;
        bit idx_ok, ov_ok, busy_ok, hold_ok;
        nr = big ? 14 : 10;
        idx_ok = 1'b1; ov_ok = 1'b1; busy_ok = 1'b1; hold_ok = 1'b1;
        drv(big, 1'b1, 1'b1, ct, 1'b0, 1'b0);
        #1 s = snap(big);
        check({tag, ".in_ready"}, 128'(s.in_ready), 128'(1'b1));
        check({tag, ".idx_idle"}, 128'(s.idx), 128'(nr));
        @(negedge clk);
        drv(big, 1'b1, 1'b0, ~ct, 1'b0, 1'b0);
        for (int j = 0; j <= nr; j++) begin
            s = snap(big);
            if (s.idx !== 4'((j < nr - 1) ? (nr - 1 - j) : 0)) idx_ok = 1'b0;
            if (s.out_valid !== (j == nr)) ov_ok = 1'b0;
            if (s.busy !== 1'b1 || s.in_ready !== 1'b0) busy_ok = 1'b0;
            if (j < nr) @(negedge clk);
        end
        check({tag, ".idx_seq"}, 128'(idx_ok), 128'(1'b1));
        check({tag, ".latency"}, 128'(ov_ok), 128'(1'b1));
        check({tag, ".busy"}, 128'(busy_ok), 128'(1'b1));
        check({tag, ".pt"}, s.pt, exp);
        for (int h = 0; h < hold; h++) begin
            drv(big, 1'b1, 1'b1, rnd(), 1'b0, 1'b0);
            #1 s = snap(big);
            if (s.in_ready !== 1'b0) hold_ok = 1'b0;
            @(negedge clk);
            s = snap(big);
            if (s.out_valid !== 1'b1 || s.pt !== exp || s.busy !== 1'b1 || s.idx !== 4'd0)
                hold_ok = 1'b0;
        end
        if (hold > 0) check({tag, ".backpressure"}, 128'(hold_ok), 128'(1'b1));
        drv(big, 1'b1, 1'b0, ct, 1'b1, 1'b0);
        #1 s = snap(big);
        check({tag, ".ov_before_edge"}, 128'(s.out_valid), 128'(1'b1));
        @(negedge clk);
        drv(big, 1'b1, 1'b0, ct, 1'b0, 1'b0);
        s = snap(big);
        check({tag, ".ov_drop"}, 128'(s.out_valid), 128'(1'b0));
        check({tag, ".idle"}, 128'({s.busy, s.idx}), 128'({1'b0, 4'(nr)}));
    endtask

    initial begin
        snap_t  s;
        bit     ok;
        state_t c, p;
        rst_n = 1'b0;
        drv(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        drv(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        build_sbox();
        key_expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 1'b0);
        key_expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 1'b1);
        repeat (2) @(negedge clk);

        s = snap(1'b0);
        check("rst10.state_q", s.sq, '0);
        check("rst10.ctl", 128'({s.idx, s.out_valid, s.busy}), 128'({4'd10, 1'b0, 1'b0}));
        s = snap(1'b1);
        check("rst14.state_q", s.sq, '0);
        check("rst14.ctl", 128'({s.idx, s.out_valid, s.busy}), 128'({4'd14, 1'b0, 1'b0}));
        rst_n = 1'b1;
        @(negedge clk);
        s = snap(1'b0);
        check("post_rst.in_ready_nokey", 128'(s.in_ready), 128'(1'b0));

        run_block(1'b0, C1_CT, FIPS_PT, "fips_c1", 0);
        run_block(1'b1, C3_CT, FIPS_PT, "fips_c3", 0);

        p = rnd(); c = encrypt(p, 1'b0);
        run_block(1'b0, c, p, "bp_first", 5);
        p = rnd(); c = encrypt(p, 1'b0);
        run_block(1'b0, c, p, "bp_b2b", 0);

        p = rnd(); c = encrypt(p, 1'b0);
        drv(1'b0, 1'b0, 1'b1, c, 1'b0, 1'b0);
        #1 s = snap(1'b0);
        check("gate.in_ready", 128'(s.in_ready), 128'(1'b0));
        @(negedge clk);
        s = snap(1'b0);
        check("gate.no_accept", 128'(s.busy), 128'(1'b0));
        run_block(1'b0, c, p, "gate_accept", 0);

        c = rnd();
        drv(1'b0, 1'b1, 1'b1, c, 1'b0, 1'b0);
        @(negedge clk);
        drv(1'b0, 1'b1, 1'b0, c, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        s = snap(1'b0);
        check("abort.idx5", 128'(s.idx), 128'(4'd5));
        drv(1'b0, 1'b1, 1'b1, c, 1'b1, 1'b1);
        #1 s = snap(1'b0);
        check("abort.in_ready_clr", 128'(s.in_ready), 128'(1'b0));
        @(negedge clk);
        drv(1'b0, 1'b1, 1'b0, c, 1'b0, 1'b0);
        s = snap(1'b0);
        check("abort.idle", 128'({s.busy, s.out_valid, s.idx}), 128'({1'b0, 1'b0, 4'd10}));
        ok = 1'b1;
        repeat (16) begin
            @(negedge clk);
            s = snap(1'b0);
            if (s.out_valid !== 1'b0 || s.busy !== 1'b0) ok = 1'b0;
        end
        check("abort.no_output", 128'(ok), 128'(1'b1));
        drv(1'b0, 1'b1, 1'b1, c, 1'b0, 1'b1);
        #1 s = snap(1'b0);
        check("clr_idle.in_ready", 128'(s.in_ready), 128'(1'b0));
        @(negedge clk);
        drv(1'b0, 1'b1, 1'b0, c, 1'b0, 1'b0);
        s = snap(1'b0);
        check("clr_idle.no_accept", 128'(s.busy), 128'(1'b0));
        p = rnd(); c = encrypt(p, 1'b0);
        run_block(1'b0, c, p, "after_abort", 0);

        c = rnd();
        drv(1'b0, 1'b1, 1'b1, c, 1'b0, 1'b0);
        @(negedge clk);
        drv(1'b0, 1'b1, 1'b0, c, 1'b0, 1'b0);
        repeat (9) @(negedge clk);
        s = snap(1'b0);
        check("rstmid.in_final", 128'({s.busy, s.idx}), 128'({1'b1, 4'd0}));
        rst_n = 1'b0;
        #1 s = snap(1'b0);
        check("rstmid.ctl", 128'({s.idx, s.out_valid, s.busy}), 128'({4'd10, 1'b0, 1'b0}));
        check("rstmid.state_q", s.sq, '0);
        @(negedge clk);
        rst_n = 1'b1;
        run_block(1'b0, C1_CT, FIPS_PT, "after_rst", 0);

        for (int n = 0; n < 3; n++) begin
            p = rnd(); c = encrypt(p, 1'b0);
            run_block(1'b0, c, p, "rand10", 0);
        end
        for (int n = 0; n < 2; n++) begin
            p = rnd(); c = encrypt(p, 1'b1);
            run_block(1'b1, c, p, "rand14", n);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
